median_ctrl: RTL and testbench
==============================

MEDIAN_CTRL -- requirements
Module: median_ctrl

Interface
REQ-001 Parameter: NUM, 9, window length of the median datapath; odd, >= 3.
REQ-002 Port: CLK  input  1  sole clock, all state on rising edge.
REQ-003 Port: nRST  input  1  reset, asynchronous, active-low.
REQ-004 Port: DSI  input  1  pixel-valid strobe from the source; high while a pixel is presented on the datapath DI bus.
REQ-005 Port: MDSI  output  1  load select to median datapath (1 = shift in DI, 0 = recirculate MIN).
REQ-006 Port: BYP  output  1  bypass select to median datapath (1 = last stage takes previous stage, 0 = takes MAX).
REQ-007 Port: DSO  output  1  one-cycle pulse: datapath DO holds the median.
REQ-008 Port: BUSY  output  1  high from first accepted DSI until the DSO cycle inclusive.
REQ-009 Port: ERR  output  1  sticky short-burst flag; present only when MEDCTRL_ERR_EN is defined.

Function
REQ-010 The block SHALL implement FSM states IDLE, LOAD, PASS, FINAL and DONE.
REQ-011 The block SHALL hold one counter CNT of width $clog2(NUM+1) and one pass index K of width $clog2((NUM+1)/2+1).
REQ-012 In IDLE, the block SHALL drive MDSI=DSI, BYP=1, DSO=0, BUSY=0.
REQ-013 In IDLE with DSI=1, the block SHALL count that cycle as load 1, go to LOAD, and set CNT=1.
REQ-014 In LOAD, the block SHALL drive MDSI=DSI, BYP=1, BUSY=1, and increment CNT on each DSI=1 cycle.
REQ-015 When CNT reaches NUM, the block SHALL go to PASS with K=1 and CNT=0.
REQ-016 In PASS, the block SHALL drive MDSI=0 and BUSY=1.
REQ-017 In PASS, BYP SHALL be 0 for the first NUM-K cycles and 1 for the last K cycles, so each pass lasts exactly NUM cycles.
REQ-018 After the last cycle of pass K, the block SHALL start pass K+1; after pass (NUM-1)/2 it SHALL go to FINAL.
REQ-019 In FINAL, the block SHALL drive MDSI=0, BYP=0, BUSY=1 for (NUM-1)/2 cycles, then go to DONE.
REQ-020 DONE SHALL last one cycle with DSO=1, BUSY=1, MDSI=0, BYP=1, then return to IDLE.
REQ-021 For NUM=9, the sequence SHALL be 9 load + 36 pass + 4 final cycles, with DSO in the 50th cycle after the first DSI.
REQ-022 In PASS, FINAL and DONE, DSI SHALL be ignored: no load and no state change.
REQ-023 A DSI in the cycle immediately after DONE SHALL be accepted from IDLE without loss (back-to-back windows).
REQ-024 MDSI, BYP, DSO and BUSY SHALL be decoded from registered state and counters only, never from a combinational path through DSI except MDSI in IDLE and LOAD.

Reset
REQ-025 On nRST=0, the block SHALL asynchronously enter IDLE with CNT=0, K=0, DSO=0, BUSY=0, BYP=1, MDSI=0, and ERR=0 when ERR is present.
REQ-026 Reset asserted mid-window SHALL abandon the window: no DSO for it, and the next DSI after release starts a fresh load.
REQ-027 Reset release SHALL be honoured on the first CLK edge after nRST rises.

Configuration
REQ-028 When MEDCTRL_ERR_EN is defined, a DSI=0 cycle in LOAD SHALL abort to IDLE, set ERR=1, and clear CNT.
REQ-029 When MEDCTRL_ERR_EN is defined, ERR SHALL clear only on reset or on the next DSI accepted from IDLE.
REQ-030 When MEDCTRL_ERR_EN is undefined, the ERR port SHALL be absent and a DSI=0 cycle in LOAD SHALL only pause counting (hold state and CNT), with MDSI=0.

Verification
REQ-031 9 consecutive DSI cycles loading 5,1,9,3,7,2,8,6,4 -> DSO single pulse at cycle 50, DO=5, BUSY falls the cycle after DSO.
REQ-032 Check BYP trace for NUM=9 -> pass 1: 8x0,1x1; pass 2: 7x0,2x1; pass 3: 6x0,3x1; pass 4: 5x0,4x1; then 4x0.
REQ-033 DSI held high through the compute phase, with a second window 1..9 starting the cycle after DSO -> second DSO 50 cycles later with DO=5, and the first result is not disturbed.
REQ-034 With MEDCTRL_ERR_EN defined, DSI high 4 cycles then low -> ERR=1, BUSY=0, no DSO; the next 9-pixel burst clears ERR and yields DSO.
REQ-035 With MEDCTRL_ERR_EN undefined, 4 DSI cycles, a 3-cycle gap, then 5 DSI cycles -> DSO 41 cycles after the last DSI, with the correct median.
REQ-036 nRST pulsed low during pass 2 -> all outputs reach reset values immediately; no DSO follows; a fresh window then completes normally.

Source files
------------

// File: rtl/median_ctrl.sv
// Sequencer for a NUM-tap median datapath: load, bubble passes, final drain, done pulse.
// Optional short-burst error detection is compiled in with `define MEDCTRL_ERR_EN.
module median_ctrl #(
   parameter int NUM = 9
) (
   input  logic CLK,
   input  logic nRST,
   input  logic DSI,
   output logic MDSI,
   output logic BYP,
   output logic DSO,
   output logic BUSY
`ifdef MEDCTRL_ERR_EN
   ,
   output logic ERR
`endif
);

   localparam int CW   = $clog2(NUM + 1);
   localparam int KW   = $clog2((NUM + 1) / 2 + 1);
   localparam int HALF = (NUM - 1) / 2;
   localparam logic [CW-1:0] LAST      = CW'(NUM - 1);
   localparam logic [CW-1:0] FINAL_END = CW'(HALF - 1);
   localparam logic [KW-1:0] LAST_PASS = KW'(HALF);

   typedef enum logic [2:0] {IDLE, LOAD, PASS, FINAL, DONE} state_t;

   state_t        state, nxt_state;
   logic [CW-1:0] cnt, nxt_cnt;
   logic [KW-1:0] k, nxt_k;
   logic [CW:0]   pass_pos;
   logic          pass_byp;
   logic          load_phase;
   logic          byp_r, dso_r, busy_r;
`ifdef MEDCTRL_ERR_EN
   logic          err_r, nxt_err;
`endif

   always_comb begin
      nxt_state = state;
      nxt_cnt   = cnt;
      nxt_k     = k;
`ifdef MEDCTRL_ERR_EN
      nxt_err   = err_r;
`endif
      unique case (state)
         IDLE: begin
            if (DSI) begin
               nxt_state = LOAD;
               nxt_cnt   = CW'(1);
`ifdef MEDCTRL_ERR_EN
               nxt_err   = 1'b0;
`endif
            end
         end
         LOAD: begin
            if (DSI) begin
               if (cnt == LAST) begin
                  nxt_state = PASS;
                  nxt_cnt   = '0;
                  nxt_k     = KW'(1);
               end else begin
                  nxt_cnt = cnt + CW'(1);
               end
            end
`ifdef MEDCTRL_ERR_EN
            else begin
               nxt_state = IDLE;
               nxt_cnt   = '0;
               nxt_err   = 1'b1;
            end
`endif
         end
         PASS: begin
            if (cnt == LAST) begin
               nxt_cnt = '0;
               if (k == LAST_PASS) begin
                  nxt_state = FINAL;
                  nxt_k     = '0;
               end else begin
                  nxt_k = k + KW'(1);
               end
            end else begin
               nxt_cnt = cnt + CW'(1);
            end
         end
         FINAL: begin
            if (cnt == FINAL_END) begin
               nxt_state = DONE;
               nxt_cnt   = '0;
            end else begin
               nxt_cnt = cnt + CW'(1);
            end
         end
         DONE: begin
            nxt_state = IDLE;
         end
         default: begin
            nxt_state = IDLE;
            nxt_cnt   = '0;
            nxt_k     = '0;
         end
      endcase
   end

   // Pass K bypasses its last K cycles: BYP once cnt + K reaches NUM.
   assign pass_pos = {1'b0, nxt_cnt} + {{(CW + 1 - KW){1'b0}}, nxt_k};
   assign pass_byp = (pass_pos >= (CW + 1)'(NUM));

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state      <= IDLE;
         cnt        <= '0;
         k          <= '0;
         load_phase <= 1'b1;
         byp_r      <= 1'b1;
         dso_r      <= 1'b0;
         busy_r     <= 1'b0;
`ifdef MEDCTRL_ERR_EN
         err_r      <= 1'b0;
`endif
      end else begin
         state      <= nxt_state;
         cnt        <= nxt_cnt;
         k          <= nxt_k;
         load_phase <= (nxt_state == IDLE) || (nxt_state == LOAD);
         byp_r      <= (nxt_state == PASS) ? pass_byp : (nxt_state != FINAL);
         dso_r      <= (nxt_state == DONE);
         busy_r     <= (nxt_state != IDLE);
`ifdef MEDCTRL_ERR_EN
         err_r      <= nxt_err;
`endif
      end
   end

   // The only combinational path from DSI: the load strobe while loading.
   assign MDSI = load_phase & DSI & nRST;
   assign BYP  = byp_r;
   assign DSO  = dso_r;
   assign BUSY = busy_r;
`ifdef MEDCTRL_ERR_EN
   assign ERR  = err_r;
`endif

endmodule

// File: tb/tb_median_ctrl.sv
// Directed testbench for median_ctrl (NUM=9); the median datapath is stood in for by
// a pixel queue filled on MDSI cycles and sorted when DSO fires.
module tb_median_ctrl;

   logic CLK  = 1'b0;
   logic nRST = 1'b1;
   logic DSI  = 1'b0;
   logic MDSI, BYP, DSO, BUSY;
`ifdef MEDCTRL_ERR_EN
   logic ERR;
`endif

   int n_checks = 0;
   int n_pass   = 0;
   int cyc, dso_cnt, dso_cyc, last_med, last_size;
   int pixq[$];
   logic byp_trace  [1:200];
   logic busy_trace [1:200];

   median_ctrl #(.NUM(9)) dut (
      .CLK (CLK),
      .nRST(nRST),
      .DSI (DSI),
      .MDSI(MDSI),
      .BYP (BYP),
      .DSO (DSO),
      .BUSY(BUSY)
`ifdef MEDCTRL_ERR_EN
      ,
      .ERR (ERR)
`endif
   );

   always #5 CLK = ~CLK;

   task automatic start_test();
      cyc       = 0;
      dso_cnt   = 0;
      dso_cyc   = 0;
      last_med  = -1;
      last_size = 0;
      pixq.delete();
   endtask

   // One clock cycle: drive DSI after the edge, sample outputs mid-cycle.
   task automatic tick(input logic d, input int px);
      int t[$];
      @(posedge CLK);
      #1;
      DSI = d;
      #3;
      cyc++;
      if (cyc <= 200) begin
         byp_trace[cyc]  = BYP;
         busy_trace[cyc] = BUSY;
      end
      if (MDSI === 1'b1) pixq.push_back(px);
      if (DSO === 1'b1) begin
         dso_cnt++;
         dso_cyc   = cyc;
         t         = pixq;
         t.sort();
         last_size = t.size();
         last_med  = (t.size() == 0) ? -1 : t[t.size() / 2];
         pixq.delete();
      end
   endtask

   task automatic test_reset();
      #3;
      nRST = 1'b0;
      DSI  = 1'b1;
      #1;
      n_checks++; if (MDSI !== 1'b0) $display("[TB] FAIL rst_mdsi: got %b expected 0", MDSI); else n_pass++;
      n_checks++; if (BYP  !== 1'b1) $display("[TB] FAIL rst_byp: got %b expected 1", BYP); else n_pass++;
      n_checks++; if (DSO  !== 1'b0) $display("[TB] FAIL rst_dso: got %b expected 0", DSO); else n_pass++;
      n_checks++; if (BUSY !== 1'b0) $display("[TB] FAIL rst_busy: got %b expected 0", BUSY); else n_pass++;
`ifdef MEDCTRL_ERR_EN
      n_checks++; if (ERR  !== 1'b0) $display("[TB] FAIL rst_err: got %b expected 0", ERR); else n_pass++;
`endif
      @(posedge CLK);
      #1;
      nRST = 1'b1;
      #1;
      n_checks++; if (MDSI !== 1'b1) $display("[TB] FAIL idle_mdsi_follow: got %b expected 1", MDSI); else n_pass++;
      @(posedge CLK);
      #1;
      n_checks++; if (BUSY !== 1'b1) $display("[TB] FAIL release_first_edge_busy: got %b expected 1", BUSY); else n_pass++;
      nRST = 1'b0;
      DSI  = 1'b0;
      #1;
      n_checks++; if (BUSY !== 1'b0) $display("[TB] FAIL rst_async_busy: got %b expected 0", BUSY); else n_pass++;
      @(posedge CLK);
      #1;
      nRST = 1'b1;
   endtask

   task automatic test_basic();
      int   px[9] = '{5, 1, 9, 3, 7, 2, 8, 6, 4};
      logic exp_byp[1:51];
      int   c, bad_cyc;
      start_test();
      for (int i = 0; i < 9; i++) tick(1'b1, px[i]);
      for (int i = 0; i < 42; i++) tick(1'b0, 0);
      c = 1;
      for (int i = 0; i < 9; i++) begin exp_byp[c] = 1'b1; c++; end
      for (int p = 1; p <= 4; p++)
         for (int j = 0; j < 9; j++) begin exp_byp[c] = (j >= 9 - p); c++; end
      for (int i = 0; i < 4; i++) begin exp_byp[c] = 1'b0; c++; end
      exp_byp[50] = 1'b1;
      exp_byp[51] = 1'b1;
      bad_cyc = 0;
      for (int i = 51; i >= 1; i--) if (byp_trace[i] !== exp_byp[i]) bad_cyc = i;
      n_checks++; if (bad_cyc != 0) $display("[TB] FAIL byp_trace: cycle %0d got %b expected %b", bad_cyc, byp_trace[bad_cyc], exp_byp[bad_cyc]); else n_pass++;
      n_checks++; if (dso_cnt != 1) $display("[TB] FAIL basic_dso_count: got %0d expected 1", dso_cnt); else n_pass++;
      n_checks++; if (dso_cyc != 50) $display("[TB] FAIL basic_dso_cycle: got %0d expected 50", dso_cyc); else n_pass++;
      n_checks++; if (last_size != 9) $display("[TB] FAIL basic_loads: got %0d expected 9", last_size); else n_pass++;
      n_checks++; if (last_med != 5) $display("[TB] FAIL basic_median: got %0d expected 5", last_med); else n_pass++;
      n_checks++; if (busy_trace[2] !== 1'b1) $display("[TB] FAIL basic_busy_load: got %b expected 1", busy_trace[2]); else n_pass++;
      n_checks++; if (busy_trace[50] !== 1'b1) $display("[TB] FAIL basic_busy_done: got %b expected 1", busy_trace[50]); else n_pass++;
      n_checks++; if (busy_trace[51] !== 1'b0) $display("[TB] FAIL basic_busy_after: got %b expected 0", busy_trace[51]); else n_pass++;
   endtask

   task automatic test_back_to_back();
      int px[9] = '{5, 1, 9, 3, 7, 2, 8, 6, 4};
      start_test();
      for (int i = 0; i < 9; i++) tick(1'b1, px[i]);
      for (int i = 0; i < 41; i++) tick(1'b1, 0);
      n_checks++; if (dso_cyc != 50) $display("[TB] FAIL b2b_first_dso_cycle: got %0d expected 50", dso_cyc); else n_pass++;
      n_checks++; if (last_size != 9) $display("[TB] FAIL b2b_first_loads: got %0d expected 9", last_size); else n_pass++;
      n_checks++; if (last_med != 5) $display("[TB] FAIL b2b_first_median: got %0d expected 5", last_med); else n_pass++;
      for (int i = 0; i < 9; i++) tick(1'b1, i + 1);
      for (int i = 0; i < 42; i++) tick(1'b0, 0);
      n_checks++; if (dso_cnt != 2) $display("[TB] FAIL b2b_dso_count: got %0d expected 2", dso_cnt); else n_pass++;
      n_checks++; if (dso_cyc != 100) $display("[TB] FAIL b2b_second_dso_cycle: got %0d expected 100", dso_cyc); else n_pass++;
      n_checks++; if (last_size != 9) $display("[TB] FAIL b2b_second_loads: got %0d expected 9", last_size); else n_pass++;
      n_checks++; if (last_med != 5) $display("[TB] FAIL b2b_second_median: got %0d expected 5", last_med); else n_pass++;
   endtask

`ifdef MEDCTRL_ERR_EN
   task automatic test_short_burst();
      int b0;
      start_test();
      for (int i = 0; i < 4; i++) tick(1'b1, 10 * (i + 1));
      tick(1'b0, 0);
      tick(1'b0, 0);
      n_checks++; if (ERR !== 1'b1) $display("[TB] FAIL err_set: got %b expected 1", ERR); else n_pass++;
      n_checks++; if (BUSY !== 1'b0) $display("[TB] FAIL err_busy: got %b expected 0", BUSY); else n_pass++;
      for (int i = 0; i < 55; i++) tick(1'b0, 0);
      n_checks++; if (dso_cnt != 0) $display("[TB] FAIL err_no_dso: got %0d expected 0", dso_cnt); else n_pass++;
      n_checks++; if (ERR !== 1'b1) $display("[TB] FAIL err_sticky: got %b expected 1", ERR); else n_pass++;
      pixq.delete();
      b0 = cyc;
      tick(1'b1, 1);
      tick(1'b1, 2);
      n_checks++; if (ERR !== 1'b0) $display("[TB] FAIL err_clear: got %b expected 0", ERR); else n_pass++;
      for (int i = 2; i < 9; i++) tick(1'b1, i + 1);
      for (int i = 0; i < 42; i++) tick(1'b0, 0);
      n_checks++; if (dso_cyc != b0 + 50) $display("[TB] FAIL err_recover_dso: got %0d expected %0d", dso_cyc, b0 + 50); else n_pass++;
      n_checks++; if (last_med != 5) $display("[TB] FAIL err_recover_median: got %0d expected 5", last_med); else n_pass++;
   endtask
`else
   task automatic test_gap();
      start_test();
      for (int i = 0; i < 4; i++) tick(1'b1, 10 * (i + 1));
      for (int i = 0; i < 3; i++) tick(1'b0, 99);
      for (int i = 4; i < 9; i++) tick(1'b1, 10 * (i + 1));
      for (int i = 0; i < 43; i++) tick(1'b0, 0);
      n_checks++; if (busy_trace[6] !== 1'b1) $display("[TB] FAIL gap_busy: got %b expected 1", busy_trace[6]); else n_pass++;
      n_checks++; if (dso_cnt != 1) $display("[TB] FAIL gap_dso_count: got %0d expected 1", dso_cnt); else n_pass++;
      n_checks++; if (dso_cyc != 53) $display("[TB] FAIL gap_dso_cycle: got %0d expected 53", dso_cyc); else n_pass++;
      n_checks++; if (last_size != 9) $display("[TB] FAIL gap_loads: got %0d expected 9", last_size); else n_pass++;
      n_checks++; if (last_med != 50) $display("[TB] FAIL gap_median: got %0d expected 50", last_med); else n_pass++;
   endtask
`endif

   task automatic test_reset_mid();
      int px[9] = '{5, 1, 9, 3, 7, 2, 8, 6, 4};
      start_test();
      for (int i = 0; i < 9; i++) tick(1'b1, px[i]);
      for (int i = 0; i < 11; i++) tick(1'b0, 0);
      @(posedge CLK);
      #2;
      DSI  = 1'b1;
      nRST = 1'b0;
      #1;
      n_checks++; if (BUSY !== 1'b0) $display("[TB] FAIL midrst_busy: got %b expected 0", BUSY); else n_pass++;
      n_checks++; if (BYP  !== 1'b1) $display("[TB] FAIL midrst_byp: got %b expected 1", BYP); else n_pass++;
      n_checks++; if (DSO  !== 1'b0) $display("[TB] FAIL midrst_dso: got %b expected 0", DSO); else n_pass++;
      n_checks++; if (MDSI !== 1'b0) $display("[TB] FAIL midrst_mdsi: got %b expected 0", MDSI); else n_pass++;
      @(posedge CLK);
      #1;
      DSI  = 1'b0;
      nRST = 1'b1;
      start_test();
      for (int i = 0; i < 45; i++) tick(1'b0, 0);
      n_checks++; if (dso_cnt != 0) $display("[TB] FAIL midrst_no_dso: got %0d expected 0", dso_cnt); else n_pass++;
      start_test();
      for (int i = 0; i < 9; i++) tick(1'b1, 11 + i);
      for (int i = 0; i < 42; i++) tick(1'b0, 0);
      n_checks++; if (dso_cyc != 50) $display("[TB] FAIL midrst_fresh_dso: got %0d expected 50", dso_cyc); else n_pass++;
      n_checks++; if (last_med != 15) $display("[TB] FAIL midrst_fresh_median: got %0d expected 15", last_med); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
`ifdef MEDCTRL_ERR_EN
      test_short_burst();
`else
      test_gap();
`endif
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
